// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Purpose: FSM state encoding and the instruction encodings the fetch stage
//          recognises (the bubble NOP and EBREAK).
// Ports:   none (package).

package fetch_pkg;

   typedef enum logic [1:0] {
      FS_RUN    = 2'd0,
      FS_DRAIN  = 2'd1,
      FS_HALTED = 2'd2
   } fetch_state_t;

   // addi x0, x0, 0 -- inserted into IF/ID whenever a bubble is needed
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush
//
// Purpose: holds the fetched instruction and its PC for decode. Flush wins over
//          load; with neither asserted the register holds.
// Ports:   clk, rst_n       - clock, async active-low reset
//          load_i, flush_i  - capture new contents / replace with a bubble
//          pc_i, pc4_i, instr_i - contents captured on load
//          pc_o, pc4_o, instr_o, valid_o - registered IF/ID contents

module if_id_reg
   import fetch_pkg::*;
#(
   parameter int AW = 32,
   parameter int IW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          flush_i,
   input  logic [AW-1:0] pc_i,
   input  logic [AW-1:0] pc4_i,
   input  logic [IW-1:0] instr_i,
   output logic [AW-1:0] pc_o,
   output logic [AW-1:0] pc4_o,
   output logic [IW-1:0] instr_o,
   output logic          valid_o
);

   localparam logic [IW-1:0] NOP_W = IW'(NOP_INSTR);

   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] pc4_q, pc4_d;
   logic [IW-1:0] instr_q, instr_d;
   logic          valid_q, valid_d;

   always_comb begin
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (flush_i) begin
         pc_d    = '0;
         pc4_d   = '0;
         instr_d = NOP_W;
         valid_d = 1'b0;
      end else if (load_i) begin
         pc_d    = pc_i;
         pc4_d   = pc4_i;
         instr_d = instr_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         pc4_q   <= '0;
         instr_q <= NOP_W;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign pc4_o   = pc4_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, next-PC mux, drain/halt FSM
//
// Purpose: owns the PC, addresses the combinational instruction memory and
//          feeds IF/ID. Redirect beats stall beats advance. Fetching EBREAK
//          parks the PC and drains the pipe for DRAIN_CYCLES unstalled cycles
//          before halting; a redirect while draining cancels the halt.
// Ports:   clk, rst_n               - clock, async active-low reset
//          stall_i                  - hold PC and IF/ID
//          redirect_i, redirect_pc_i - taken branch/jump and its target
//          imem_addr_o, imem_instr_i - instruction memory address / data
//          if_id_*_o                - IF/ID register contents
//          halted_o                 - stage has halted after EBREAK

module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                 INS_ADDRESS  = 32,
   parameter int                 INS_W        = 32,
   parameter logic [INS_ADDRESS-1:0] RESET_PC = '0,
   parameter int                 DRAIN_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [INS_ADDRESS-1:0] redirect_pc_i,
   output logic [INS_ADDRESS-1:0] imem_addr_o,
   input  logic [INS_W-1:0]       imem_instr_i,
   output logic [INS_ADDRESS-1:0] if_id_pc_o,
   output logic [INS_ADDRESS-1:0] if_id_pc4_o,
   output logic [INS_W-1:0]       if_id_instr_o,
   output logic                   if_id_valid_o,
   output logic                   halted_o
);

   localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [INS_W-1:0] EBREAK_W = INS_W'(EBREAK_INSTR);

   fetch_state_t           state_q, state_d;
   logic [INS_ADDRESS-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   halted_q, halted_d;
   logic                   load, flush;
   logic [INS_ADDRESS-1:0] pc_plus4;
   logic [INS_ADDRESS-1:0] redirect_tgt;
   logic                   unused_redirect_lsbs;

   assign pc_plus4             = pc_q + INS_ADDRESS'(4);
   // Targets are forced word-aligned; the dropped low bits are deliberately unused.
   assign redirect_tgt         = {redirect_pc_i[INS_ADDRESS-1:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      flush   = 1'b0;
      case (state_q)
         FS_RUN: begin
            if (redirect_i) begin
               pc_d  = redirect_tgt;
               flush = 1'b1;
            end else if (!stall_i) begin
               load = 1'b1;
               if (imem_instr_i == EBREAK_W) begin
                  // EBREAK goes downstream but nothing after it is fetched
                  state_d = FS_DRAIN;
                  cnt_d   = CNT_W'(DRAIN_CYCLES);
               end else begin
                  pc_d = pc_plus4;
               end
            end
         end
         FS_DRAIN: begin
            if (redirect_i) begin
               // EBREAK was on the wrong path; behave exactly like a RUN redirect
               pc_d    = redirect_tgt;
               flush   = 1'b1;
               cnt_d   = '0;
               state_d = FS_RUN;
            end else if (!stall_i) begin
               flush = 1'b1;
               if (cnt_q <= CNT_W'(1)) begin
                  cnt_d   = '0;
                  state_d = FS_HALTED;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         FS_HALTED: begin
            // frozen until reset
         end
         default: state_d = FS_RUN;
      endcase
      halted_d = (state_d == FS_HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FS_RUN;
         pc_q     <= RESET_PC;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   if_id_reg #(
      .AW(INS_ADDRESS),
      .IW(INS_W)
   ) u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .flush_i (flush),
      .pc_i    (pc_q),
      .pc4_i   (pc_plus4),
      .instr_i (imem_instr_i),
      .pc_o    (if_id_pc_o),
      .pc4_o   (if_id_pc4_o),
      .instr_o (if_id_instr_o),
      .valid_o (if_id_valid_o)
   );

   assign imem_addr_o = pc_q;
   assign halted_o    = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic [31:0] if_id_pc_o;
   logic [31:0] if_id_pc4_o;
   logic [31:0] if_id_instr_o;
   logic        if_id_valid_o;
   logic        halted_o;

   logic [31:0] mem [0:63];
   int          errors = 0;
   int          checks = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] EBK = 32'h0010_0073;

   always #5 clk = ~clk;

   assign imem_instr_i = mem[imem_addr_o[7:2]];

   fetch_stage #(
      .INS_ADDRESS (32),
      .INS_W       (32),
      .RESET_PC    (32'h0),
      .DRAIN_CYCLES(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .imem_addr_o  (imem_addr_o),
      .imem_instr_i (imem_instr_i),
      .if_id_pc_o   (if_id_pc_o),
      .if_id_pc4_o  (if_id_pc4_o),
      .if_id_instr_o(if_id_instr_o),
      .if_id_valid_o(if_id_valid_o),
      .halted_o     (halted_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // one clock edge, then sample on the following falling edge
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                           input logic [31:0] ins, input logic vld);
      check({tag, "_pc"},    if_id_pc_o,    pc);
      check({tag, "_pc4"},   if_id_pc4_o,   pc4);
      check({tag, "_instr"}, if_id_instr_o, ins);
      check({tag, "_valid"}, {31'd0, if_id_valid_o}, {31'd0, vld});
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_addr"}, imem_addr_o, 32'h0);
      chk_ifid(tag, 32'h0, 32'h0, NOP, 1'b0);
      check({tag, "_halt"}, {31'd0, halted_o}, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = NOP;
      mem[0]  = 32'h0010_0093;
      mem[1]  = 32'h0030_0113;
      mem[2]  = 32'h0050_0193;
      mem[7]  = EBK;
      mem[10] = 32'h0031_2403;
      mem[63] = 32'h0070_0393;

      rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      @(negedge clk);
      chk_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // sequential fetch from reset
      cyc();
      check("f0_addr", imem_addr_o, 32'h4);
      chk_ifid("f0", 32'h0, 32'h4, 32'h0010_0093, 1'b1);
      cyc();
      check("f1_addr", imem_addr_o, 32'h8);
      chk_ifid("f1", 32'h4, 32'h8, 32'h0030_0113, 1'b1);

      // stall two cycles at PC=8
      stall_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cyc();
         check("stl_addr", imem_addr_o, 32'h8);
         chk_ifid("stl", 32'h4, 32'h8, 32'h0030_0113, 1'b1);
      end
      stall_i = 1'b0;
      cyc();
      check("res_addr", imem_addr_o, 32'hC);
      chk_ifid("res", 32'h8, 32'hC, 32'h0050_0193, 1'b1);

      // redirect beats stall, target low bits dropped
      stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h2B;
      cyc();
      check("rd_addr", imem_addr_o, 32'h28);
      chk_ifid("rd_bub", 32'h0, 32'h0, NOP, 1'b0);
      stall_i = 1'b0; redirect_i = 1'b0;
      cyc();
      check("rd_addr2", imem_addr_o, 32'h2C);
      chk_ifid("rd_tgt", 32'h28, 32'h2C, 32'h0031_2403, 1'b1);

      // EBREAK at 0x1C drains and halts; a stall in DRAIN delays the halt
      redirect_i = 1'b1; redirect_pc_i = 32'h1C;
      cyc();
      redirect_i = 1'b0;
      cyc();
      check("eb_addr", imem_addr_o, 32'h1C);
      chk_ifid("eb", 32'h1C, 32'h20, EBK, 1'b1);
      check("eb_halt", {31'd0, halted_o}, 32'h0);
      stall_i = 1'b1;
      cyc();
      chk_ifid("eb_stl", 32'h1C, 32'h20, EBK, 1'b1);
      check("eb_stl_halt", {31'd0, halted_o}, 32'h0);
      stall_i = 1'b0;
      cyc();
      chk_ifid("dr1", 32'h0, 32'h0, NOP, 1'b0);
      check("dr1_halt", {31'd0, halted_o}, 32'h0);
      check("dr1_addr", imem_addr_o, 32'h1C);
      cyc();
      check("dr2_halt", {31'd0, halted_o}, 32'h1);
      check("dr2_addr", imem_addr_o, 32'h1C);
      redirect_i = 1'b1; redirect_pc_i = 32'h0;
      cyc();
      redirect_i = 1'b0;
      check("hlt_halt", {31'd0, halted_o}, 32'h1);
      check("hlt_addr", imem_addr_o, 32'h1C);
      chk_ifid("hlt", 32'h0, 32'h0, NOP, 1'b0);

      // reset exits HALTED
      rst_n = 1'b0;
      #1;
      chk_reset("rst2");
      @(negedge clk);
      rst_n = 1'b1;

      // EBREAK then redirect in DRAIN cancels the halt
      redirect_i = 1'b1; redirect_pc_i = 32'h1C;
      cyc();
      redirect_i = 1'b0;
      cyc();
      chk_ifid("eb2", 32'h1C, 32'h20, EBK, 1'b1);
      redirect_i = 1'b1; redirect_pc_i = 32'h0;
      cyc();
      redirect_i = 1'b0;
      check("cx_addr", imem_addr_o, 32'h0);
      chk_ifid("cx_bub", 32'h0, 32'h0, NOP, 1'b0);
      cyc();
      check("cx_addr2", imem_addr_o, 32'h4);
      chk_ifid("cx_f0", 32'h0, 32'h4, 32'h0010_0093, 1'b1);
      cyc(); cyc(); cyc();
      check("cx_halt", {31'd0, halted_o}, 32'h0);
      check("cx_addr3", imem_addr_o, 32'h10);

      // async reset asserted while draining
      redirect_i = 1'b1; redirect_pc_i = 32'h1C;
      cyc();
      redirect_i = 1'b0;
      cyc();
      chk_ifid("eb3", 32'h1C, 32'h20, EBK, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset("rst3");
      @(negedge clk);
      rst_n = 1'b1;
      cyc(); cyc(); cyc();
      check("rst3_halt", {31'd0, halted_o}, 32'h0);

      // PC wrap at the top of the address space
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      cyc();
      redirect_i = 1'b0;
      check("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
      cyc();
      check("wr_addr2", imem_addr_o, 32'h0);
      chk_ifid("wr", 32'hFFFF_FFFC, 32'h0, 32'h0070_0393, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core. Owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Handles stall, branch/jump redirect with flush, and an EBREAK-triggered drain-then-halt sequence. It sits directly upstream of instruction memory (address) and decode (IF/ID outputs).

## Interface
- INS_ADDRESS, 32: PC / memory address width.
- INS_W, 32: instruction width.
- RESET_PC, 0: PC value after reset.
- DRAIN_CYCLES, 2: cycles to wait after fetching EBREAK before halting; equals fetch-to-EX branch-resolution distance.
- clk in 1: clock. Only clock; all state updates on posedge.
- rst_n in 1: asynchronous, active-low reset.
- stall_i in 1: hold PC and IF/ID (hazard unit).
- redirect_i in 1: taken branch/jump from EX.
- redirect_pc_i in INS_ADDRESS: redirect target.
- imem_addr_o out INS_ADDRESS: byte address to instruction memory; equals PC register, no logic after the flop.
- imem_instr_i in INS_W: instruction word returned combinationally for imem_addr_o.
- if_id_pc_o out INS_ADDRESS: PC of captured instruction.
- if_id_pc4_o out INS_ADDRESS: if_id_pc_o + 4 (link value).
- if_id_instr_o out INS_W: captured instruction.
- if_id_valid_o out 1: captured instruction is real (0 = bubble).
- halted_o out 1: stage in HALTED.

## Operation
- States: RUN, DRAIN, HALTED. Reset to RUN.
- Priority per cycle: redirect_i > stall_i > normal advance. In HALTED, all inputs ignored.
- RUN, redirect_i=1: PC <= {redirect_pc_i[INS_ADDRESS-1:2], 2'b00}; IF/ID <= bubble (instr 0x00000013, valid 0, pc/pc4 0). Redirect during stall still applies.
- RUN, stall_i=1, no redirect: PC and IF/ID hold.
- RUN, normal: IF/ID <= {PC, PC+4, imem_instr_i, valid 1}; PC <= PC+4 (mod 2^INS_ADDRESS; 0xFFFFFFFC wraps to 0). If imem_instr_i == 0x00100073 (EBREAK): PC holds instead, state -> DRAIN, drain counter <= DRAIN_CYCLES.
- DRAIN: PC held; IF/ID <= bubble each unstalled cycle (EBREAK remains in pipeline downstream). Counter decrements only when stall_i=0; at counter==1 decrement -> HALTED. redirect_i=1 in DRAIN: EBREAK was wrong-path; apply RUN redirect behaviour, counter <= 0, state -> RUN.
- HALTED: PC and IF/ID frozen; halted_o=1. Exit only via rst_n.

## Timing
- Reset (async assert, sync-safe deassert by top level): PC=RESET_PC, if_id_pc_o=0, if_id_pc4_o=0, if_id_instr_o=0x00000013, if_id_valid_o=0, halted_o=0, counter 0.
- First fetch address is RESET_PC in the cycle rst_n deasserts; instruction at address A appears on IF/ID one cycle after imem_addr_o==A.
- Redirect penalty: one bubble; target instruction in IF/ID two cycles after redirect_i sampled.
- halted_o rises exactly DRAIN_CYCLES unstalled cycles after the edge that captured EBREAK.
- All outputs registered except imem_addr_o (direct PC flop).

## Structure
- fetch_pkg: fetch_state_t enum {FS_RUN, FS_DRAIN, FS_HALTED}, NOP_INSTR=0x00000013, EBREAK_INSTR=0x00100073.
- Sub-module if_id_reg: IF/ID register with load/hold/flush controls and async reset; fetch_stage holds PC, next-PC mux, FSM, drain counter.

## Test plan
- Reset release, memory holds 0x00100093@0, 0x00300113@4: imem_addr_o 0,4,8; IF/ID shows {pc 0, 0x00100093, valid 1} then {pc 4, pc4 8, 0x00300113}.
- stall_i high two cycles while PC=8: PC stays 8, IF/ID holds {pc 4, 0x00300113, valid 1}; resumes with pc 8 next.
- redirect_i with stall_i both high, redirect_pc_i=0x2B, 0x00312403@0x28: PC=0x28, IF/ID bubble (0x13, valid 0), then {pc 0x28, 0x00312403, valid 1}.
- EBREAK@0x1C, no redirect, DRAIN_CYCLES=2: IF/ID gets EBREAK, PC holds 0x1C, two bubbles, halted_o=1; later redirect ignored.
- EBREAK@0x1C then redirect to 0x0 next cycle: state RUN, halted_o stays 0, fetch resumes at 0.
- rst_n asserted in DRAIN, and PC at 0xFFFFFFFC unstalled: reset values restored immediately; wrap yields PC=0.
